// File: rtl/md_scheduler_pkg.sv
// Shared encodings for the multiply/divide unit: E-stage md_op codes, scheduler states,
// and small op-class helpers used by the decoder, hazard unit and scheduler.
package md_scheduler_pkg;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  function automatic logic md_is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_start(input logic [2:0] op);
    return md_is_mul(op) || md_is_div(op);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational mult/div datapath producing the HI/LO pair for a started md op.
// Non-arithmetic ops and division by zero pass the current HI/LO through unchanged.
module md_arith
  import md_scheduler_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic        sgn;
  logic        rs_neg;
  logic        rt_neg;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    sgn    = (op == MD_MULT) || (op == MD_DIV);
    rs_neg = sgn & rs[31];
    rt_neg = sgn & rt[31];
    // Low 64 bits of the product of the extended operands equal the true product.
    a_ext  = {{32{rs_neg}}, rs};
    b_ext  = {{32{rt_neg}}, rt};
    prod   = a_ext * b_ext;
    // Signed divide on magnitudes; 0x80000000 stays 0x80000000 as an unsigned magnitude,
    // which makes the -2^31 / -1 case fall out as quotient 0x80000000, remainder 0.
    num    = rs_neg ? (32'd0 - rs) : rs;
    den    = rt_neg ? (32'd0 - rt) : rt;
    quo    = '0;
    rem    = '0;
    if (den != 32'd0) begin
      quo = num / den;
      rem = num % den;
    end
    res_hi = cur_hi;
    res_lo = cur_lo;
    if (md_is_mul(op)) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (md_is_div(op) && (rt != 32'd0)) begin
      res_lo = (rs_neg ^ rt_neg) ? (32'd0 - quo) : quo;
      res_hi = rs_neg ? (32'd0 - rem) : rem;
    end
  end

endmodule

// File: rtl/md_scheduler.sv
// E-stage multiply/divide scheduler: captures the result at the start edge, holds busy for
// a fixed latency, then commits to HI/LO. mthi/mtlo write HI/LO directly when idle.
module md_scheduler
  import md_scheduler_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        md_stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      tmp_hi_q, tmp_hi_d;
  logic [31:0]      tmp_lo_q, tmp_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             busy_q, busy_d;
  logic [31:0]      res_hi, res_lo;

  md_arith u_arith (
    .op     (md_op),
    .rs     (rs_val),
    .rt     (rt_val),
    .cur_hi (hi_q),
    .cur_lo (lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (md_is_start(md_op)) begin
          tmp_hi_d = res_hi;
          tmp_lo_d = res_lo;
          cnt_d    = md_is_mul(md_op) ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
          state_d  = MD_RUN;
        end else if (md_op == MD_MTHI) begin
          hi_d = rs_val;
        end else if (md_op == MD_MTLO) begin
          lo_d = rs_val;
        end
      end
      // Any op arriving here is ignored; the hazard unit keeps md ops out of E while busy.
      MD_RUN: begin
        if (cnt_q == '0) begin
          hi_d    = tmp_hi_q;
          lo_d    = tmp_lo_q;
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
    busy_d = (state_d == MD_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
    end
  end

  assign busy         = busy_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign md_stall_req = busy_q | md_is_start(md_op);

endmodule

// File: tb/tb_md_scheduler.sv
// Directed + randomized bench for md_scheduler against a cycle-count reference model
// built on 64-bit integer arithmetic.
module tb_md_scheduler;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        busy, md_stall_req;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left;

  md_scheduler #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .md_op        (md_op),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .busy         (busy),
    .md_stall_req (md_stall_req),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_start(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  // Reference result: HI/LO as the architecture defines them, from wide integer math.
  task automatic ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = m_hi;
    rl = m_lo;
    case (op)
      3'd1: begin u = 64'(sa * sb); rh = u[63:32]; rl = u[31:0]; end
      3'd2: begin u = {32'd0, a} * {32'd0, b}; rh = u[63:32]; rl = u[31:0]; end
      3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
      3'd4: if (b != 0) begin rl = a / b; rh = a % b; end
      default: ;
    endcase
  endtask

  task automatic cyc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op  = op;
    rs_val = a;
    rt_val = b;
    #1;
    chk("stall_req", {31'd0, md_stall_req}, {31'd0, (m_left > 0) || is_start(op)});
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (is_start(op)) begin
      ref_result(op, a, b, p_hi, p_lo);
      m_left = (op <= 3'd2) ? MULT_CYCLES : DIV_CYCLES;
    end else if (op == 3'd5) m_hi = a;
    else if (op == 3'd6) m_lo = a;
    #1;
    chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  task automatic idle(input int n, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < n; i++) begin
      cyc(3'd0, 32'd0, 32'd0);
      if (busy) nbusy++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    logic [2:0] op;
    reset  = 1'b0;
    md_op  = 3'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_left = 0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    cyc(3'd1, 32'hFFFF_FFFF, 32'd2);
    idle(6, nb);
    chk("mult_busy_cycles", 32'(nb + 1), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    cyc(3'd2, 32'hFFFF_FFFF, 32'd2);
    idle(6, nb);
    chk("multu_busy_cycles", 32'(nb + 1), 32'd5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    cyc(3'd3, 32'hFFFF_FFF9, 32'd2);
    idle(11, nb);
    chk("div_busy_cycles", 32'(nb + 1), 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    cyc(3'd5, 32'h0000_1234, 32'd0);
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    cyc(3'd4, 32'd77, 32'd0);
    idle(11, nb);
    chk("divu0_busy_cycles", 32'(nb + 1), 32'd10);
    chk("divu0_hi", hi, 32'h0000_1234);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);

    cyc(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10, nb);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    cyc(3'd1, 32'd3, 32'd4);
    cyc(3'd6, 32'h0000_AAAA, 32'd0);
    idle(4, nb);
    chk("mtlo_ignored_lo", lo, 32'd12);
    chk("mtlo_idle_again", {31'd0, busy}, 32'd0);
    cyc(3'd1, 32'd5, 32'd6);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    idle(5, nb);
    chk("b2b_lo", lo, 32'd30);

    cyc(3'd3, 32'd100, 32'd7);
    idle(3, nb);
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    m_hi = 0; m_lo = 0; m_left = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("postrst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      if (m_left > 0) op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      else op = 3'($urandom_range(0, 7));
      cyc(op, pick(), pick());
    end
    idle(11, nb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
